// File: rtl/mem_rw_seq.sv
// mem_rw_seq: block-memory write/read sequencer.
// A debounced button press fills a single-port synchronous RAM with
// pat(a) = PAT_BASE + a*PAT_STEP. The RAM is then read back in a loop, and
// each word is shown on led for HOLD_CYC cycles. Another press stops the loop.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   button       raw asynchronous push-button
//   ena, wea     RAM enable / write enable
//   addra, dina  RAM address / write data
//   douta        RAM read data, valid RD_LAT cycles after the address
//   led          last captured read-back word
//   busy         high in every state except IDLE
//   err          sticky read-back mismatch flag
//
// Optional feature: define MEM_RW_VERIFY_EN to compare each captured word
// against pat(a). Without it, err is tied to 0.
module mem_rw_seq #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned DEB_CYC  = 200000,
  parameter int unsigned HOLD_CYC = 10000000,
  parameter int unsigned PAT_BASE = 1,
  parameter int unsigned PAT_STEP = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DW = $clog2(DEB_CYC + 2);
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [DW-1:0]     DEB_HIT   = DW'(DEB_CYC);
  localparam logic [DW-1:0]     DEB_SAT   = DW'(DEB_CYC + 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, HOLD} state_t;

  state_t            state, next;
  logic [1:0]        sync;
  logic [DW-1:0]     deb_cnt;
  logic              press;
  logic [ADDR_W-1:0] a;
  logic [1:0]        wcnt;
  logic [HW-1:0]     hcnt;
  logic [DATA_W-1:0] pat_a;
  logic              capture;

  assign pat_a = DATA_W'(PAT_BASE) + DATA_W'(a) * DATA_W'(PAT_STEP);

  // A press stops the read loop, so the read in flight is not captured.
  assign capture = (state == RD_WAIT) && (wcnt == WAIT_LAST) && !press;

  // The counter stops at DEB_CYC+1. After that, press stays low until the
  // level drops and clears it. The press register is set on the edge after
  // the count reaches DEB_CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync <= {sync[0], button};
      if (sync[1]) begin
        if (deb_cnt != DEB_SAT) deb_cnt <= deb_cnt + DW'(1);
        press <= (deb_cnt == DEB_HIT);
      end else begin
        deb_cnt <= '0;
        press   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (press) next = WRITE;
      WRITE:   if (a == ADDR_LAST) next = RD_ADDR;
      RD_ADDR: next = press ? IDLE : RD_WAIT;
      RD_WAIT: if (press) next = IDLE;
               else if (wcnt == WAIT_LAST) next = HOLD;
      HOLD:    if (press) next = IDLE;
               else if (hcnt == HOLD_LAST) next = RD_ADDR;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    ena   = (state == WRITE) || (state == RD_ADDR) || (state == RD_WAIT);
    wea   = (state == WRITE);
    addra = a;
    dina  = (state == WRITE) ? pat_a : '0;
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a    <= '0;
      wcnt <= '0;
      hcnt <= '0;
      led  <= '0;
    end else begin
      wcnt <= (state == RD_WAIT) ? wcnt + 2'd1 : '0;
      hcnt <= (state == HOLD) ? hcnt + HW'(1) : '0;
      if (state == IDLE && press)
        a <= '0;
      else if (state == WRITE)
        a <= a + ADDR_W'(1);
      else if (state == HOLD && hcnt == HOLD_LAST && !press)
        a <= a + ADDR_W'(1);
      if (capture) led <= douta;
    end
  end

`ifdef MEM_RW_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             err <= 1'b0;
    else if (capture && douta != pat_a)  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rw_seq.sv
// tb_mem_rw_seq: three sequencers (RD_LAT = 1, 2, 3; DEB_CYC=4, HOLD_CYC=3)
// with separate buttons and RAM models, sharing one clock and reset.
// Expected writes and read-back words go into per-instance queues when a
// press is driven. Monitors pop and compare them as the DUT produces output.
module tb_mem_rw_seq;

  localparam bit VERIFY =
`ifdef MEM_RW_VERIFY_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed { logic [3:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [15:0] data; logic err; } rd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn     [3];
  logic        corrupt [3];
  logic        ena_v   [3];
  logic        wea_v   [3];
  logic [3:0]  addra_v [3];
  logic [15:0] dina_v  [3];
  logic [15:0] douta_v [3];
  logic [15:0] led_v   [3];
  logic        busy_v  [3];
  logic        err_v   [3];

  wr_t exp_w [3][$];
  rd_t exp_r [3][$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int ad);
    return 16'(1 + 3 * ad);
  endfunction

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, expv);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [15:0] mem  [16];
    logic [15:0] pipe [3];

    mem_rw_seq #(
      .DATA_W(16), .ADDR_W(4), .RD_LAT(g + 1), .DEB_CYC(4),
      .HOLD_CYC(3), .PAT_BASE(1), .PAT_STEP(3)
    ) u_dut (
      .clk(clk), .rst(rst), .button(btn[g]),
      .ena(ena_v[g]), .wea(wea_v[g]), .addra(addra_v[g]), .dina(dina_v[g]),
      .douta(douta_v[g]), .led(led_v[g]), .busy(busy_v[g]), .err(err_v[g])
    );

    // RAM model. The read pipeline has RD_LAT = g+1 stages. When corrupt is
    // set, address 7 stores the inverted word.
    always @(posedge clk) begin
      if (ena_v[g] && wea_v[g])
        mem[addra_v[g]] <= (corrupt[g] && addra_v[g] == 4'd7) ? ~dina_v[g] : dina_v[g];
      if (ena_v[g]) pipe[0] <= mem[addra_v[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign douta_v[g] = pipe[g];

    initial begin
      int          ncyc = 0;
      int          last_t = 0;
      bit          seen = 0;
      logic [15:0] last_led = '0;
      wr_t         w;
      rd_t         r;
      forever begin
        @(negedge clk);
        ncyc++;
        if (rst) begin
          last_led = '0;
          seen     = 0;
        end else begin
          if (ena_v[g] && wea_v[g]) begin
            total++;
            assert (exp_w[g].size() != 0) else begin
              bad++;
              $error("FAIL wr_extra[%0d] observed addr=%0h expected no write", g, addra_v[g]);
            end
            if (exp_w[g].size() != 0) begin
              w = exp_w[g].pop_front();
              chk("wr_addr", g, 32'(addra_v[g]), 32'(w.addr));
              chk("wr_data", g, 32'(dina_v[g]), 32'(w.data));
            end
          end
          if (led_v[g] !== last_led) begin
            total++;
            assert (exp_r[g].size() != 0) else begin
              bad++;
              $error("FAIL rd_extra[%0d] observed led=%0h expected no update", g, led_v[g]);
            end
            if (exp_r[g].size() != 0) begin
              r = exp_r[g].pop_front();
              chk("rd_led", g, 32'(led_v[g]), 32'(r.data));
              chk("rd_err", g, 32'(err_v[g]), 32'(r.err));
              if (seen) chk("rd_gap", g, 32'(ncyc - last_t), 32'(g + 5));
            end
            last_t   = ncyc;
            seen     = 1;
            last_led = led_v[g];
          end
        end
      end
    end
  end

  task automatic arm(input int idx, input int nread, input bit cor);
    logic [15:0] d;
    logic        e;
    exp_w[idx].delete();
    exp_r[idx].delete();
    for (int ad = 0; ad < 16; ad++) exp_w[idx].push_back(wr_t'{4'(ad), pat(ad)});
    e = 1'b0;
    for (int k = 0; k < nread; k++) begin
      d = pat(k % 16);
      if (cor && (k % 16) == 7) begin
        d = ~d;
        if (VERIFY) e = 1'b1;
      end
      exp_r[idx].push_back(rd_t'{d, e});
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_ena"},   i, 32'(ena_v[i]),   0);
      chk({tag, "_wea"},   i, 32'(wea_v[i]),   0);
      chk({tag, "_addra"}, i, 32'(addra_v[i]), 0);
      chk({tag, "_dina"},  i, 32'(dina_v[i]),  0);
      chk({tag, "_led"},   i, 32'(led_v[i]),   0);
      chk({tag, "_busy"},  i, 32'(busy_v[i]),  0);
      chk({tag, "_err"},   i, 32'(err_v[i]),   0);
    end
  endtask

  // Glitch, press, full write, read loop through one wrap, then a stop
  // press that lands in the middle HOLD cycle of address 5 on the second lap.
  task automatic run_inst(input int idx);
    int lat, per, e_stop;
    lat    = idx + 1;
    per    = lat + 4;
    e_stop = 24 + 21 * per + lat + 1;
    @(negedge clk) btn[idx] = 1'b1;
    repeat (3) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy", idx, 32'(busy_v[idx]), 0);
    arm(idx, 22, idx == 1);
    corrupt[idx] = (idx == 1);
    @(negedge clk) btn[idx] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      chk("press_busy", idx, 32'(busy_v[idx]), 32'(e == 7));
    end
    repeat (3) @(negedge clk);
    btn[idx] = 1'b0;
    repeat (e_stop - 16) @(negedge clk);
    btn[idx] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("stop_busy", idx, 32'(busy_v[idx]), 0);
    chk("stop_ena",  idx, 32'(ena_v[idx]),  0);
    chk("stop_led",  idx, 32'(led_v[idx]),  32'(pat(5)));
    @(negedge clk) btn[idx] = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", idx, 32'(busy_v[idx]), 0);
    chk("idle_led",  idx, 32'(led_v[idx]),  32'(pat(5)));
    chk("idle_err",  idx, 32'(err_v[idx]),  32'(VERIFY && idx == 1));
    chk("wr_left",   idx, 32'(exp_w[idx].size()), 0);
    chk("rd_left",   idx, 32'(exp_r[idx].size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn[i]     = 1'b0;
      corrupt[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 3; i++) run_inst(i);

    // Reset held for 5 cycles in the middle of a write pass.
    arm(0, 16, 0);
    @(negedge clk) btn[0] = 1'b1;
    repeat (16) @(negedge clk);
    rst    = 1'b1;
    btn[0] = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("midrst");
    exp_w[0].delete();
    exp_r[0].delete();
    rst = 1'b0;

    // The next press must restart the write at address 0.
    arm(0, 2, 0);
    @(negedge clk) btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    btn[0] = 1'b0;
    repeat (22) @(negedge clk);
    chk("restart_wr_left", 0, 32'(exp_w[0].size()), 0);
    chk("restart_rd_left", 0, 32'(exp_r[0].size()), 0);
    chk("restart_busy",    0, 32'(busy_v[0]), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("endrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_rw_seq.md
# mem_rw_seq

Parametrised block-memory write/read sequencer, successor to the fixed 16x16 LED memory controller. On a debounced button press it fills a single-port synchronous RAM with a generated pattern. It then reads the RAM back in a continuous loop and shows each word on `led` for a programmable dwell time. It sits between the board button/LED pins and a single-port BRAM (ena/wea/addra/dina/douta style), in the divided-clock domain.

## Interface
- `DATA_W`, 16: RAM word width and `led` width.
- `ADDR_W`, 4: RAM address width; depth = 2^ADDR_W.
- `RD_LAT`, 1: RAM read latency in cycles (1..3) from address to valid `douta`.
- `DEB_CYC`, 200000: cycles the synchronised button must stay high to count as a press.
- `HOLD_CYC`, 10000000: display dwell per word during read-back, in cycles (>=1).
- `PAT_BASE`, 1: pattern word for address 0.
- `PAT_STEP`, 3: pattern increment per address.
- `clk` in 1: single clock (divided board clock); all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `button` in 1: raw, asynchronous push-button.
- `ena` out 1: RAM enable.
- `wea` out 1: RAM write enable.
- `addra` out ADDR_W: RAM address.
- `dina` out DATA_W: RAM write data.
- `douta` in DATA_W: RAM read data.
- `led` out DATA_W: displayed word.
- `busy` out 1: high in WRITE and READ.
- `err` out 1: sticky read-back mismatch flag (see Configuration).

## Operation
- Button path: 2-flop synchroniser, then debounce counter. The counter increments while the synchronised level is high and clears when it is low. A single-cycle `press` fires when the count reaches DEB_CYC. No further press is generated until the level returns low.
- Pattern: `pat(a) = (PAT_BASE + a*PAT_STEP) mod 2^DATA_W`.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, HOLD.
- IDLE:
  - `ena=0`, `wea=0`; `led` holds its last value.
  - On `press` -> WRITE with `addra=0`.
- WRITE:
  - Each cycle drives `ena=1`, `wea=1`, `addra=a`, `dina=pat(a)`.
  - `a` increments each cycle.
  - After address 2^ADDR_W-1 -> RD_ADDR with `addra=0`.
  - A `press` during WRITE is ignored.
- RD_ADDR:
  - One cycle with `ena=1`, `wea=0`, `addra=a`.
  - Then -> RD_WAIT.
- RD_WAIT:
  - Lasts RD_LAT cycles with `ena=1`.
  - On its final cycle `douta` is valid; `led <= douta`.
  - Then -> HOLD.
- HOLD:
  - Lasts HOLD_CYC cycles with `ena=0`.
  - Then `a <= a+1`, wrapping from 2^ADDR_W-1 to 0, and -> RD_ADDR.
- `press` in RD_ADDR, RD_WAIT or HOLD -> IDLE at the next edge. `led` keeps the last captured word; an in-flight read is discarded.
- `busy` = state is not IDLE.

## Timing
- Reset values: `ena=0`, `wea=0`, `addra=0`, `dina=0`, `led=0`, `busy=0`, `err=0`, state IDLE, debounce counter 0.
- Press latency: button high at a synchroniser input edge gives `press` 2+DEB_CYC cycles later. WRITE begins on the following cycle.
- WRITE occupies exactly 2^ADDR_W cycles.
- The first read address is issued in the cycle after the last write.
- Per-word read period is 1+RD_LAT+HOLD_CYC cycles. `led` updates on the edge ending RD_WAIT.
- `rst` asserted mid-operation forces all reset values immediately, including mid-WRITE. RAM contents are not cleared.
- Simultaneous `rst` and `press`: reset wins.
- Address counter arithmetic is ADDR_W bits, modulo 2^ADDR_W.

## Configuration
- `MEM_RW_VERIFY_EN` defined:
  - At each `led` capture, compare `douta` with `pat(a)`.
  - A mismatch sets `err`, which stays set until `rst`.
  - A new WRITE pass does not clear `err`.
- `MEM_RW_VERIFY_EN` undefined:
  - No comparator is built; `err` is constant 0.

## Test plan
- Reset: hold `rst` 5 cycles mid-WRITE -> all outputs 0, state IDLE, next press restarts the write at `addra=0`.
- Debounce (DEB_CYC=4): 3-cycle high glitch -> no WRITE. High for 10 cycles -> exactly one WRITE pass, `busy` rises 7 cycles after button rise.
- Write pass (defaults): 16 consecutive cycles with `wea=1`, addresses 0..15, `dina` = 1, 4, 7, ..., 46.
- Read loop (RD_LAT=2, HOLD_CYC=3): `led` sequence 1, 4, 7, ... with 6 cycles between updates. After 46 it wraps to 1.
- Stop and latency sweep: press during HOLD at address 5 -> IDLE, `led`=16, `busy`=0. Repeat with RD_LAT=1 and RD_LAT=3 to confirm correct capture.
- Verify (macro on): a RAM model corrupts address 7 -> `err` rises at the address-7 capture and stays 1 across wrap. With the macro off, `err` stays 0.
